// File: rtl/pstack_ctrl_pkg.sv
// Shared definitions for the predicate-stack command controller.
// Latency: n/a (types, constants and a pure legality function).
// Backpressure: n/a.
package pstack_ctrl_pkg;

   localparam int PSTACK_DEPTH   = 8;
   localparam int PSTACK_N_CORES = 4;

   // Branch command encodings as presented by the instruction decoder
   typedef enum logic [1:0] {
      BR_OP_IF    = 2'd0,
      BR_OP_ELSE  = 2'd1,
      BR_OP_ENDIF = 2'd2,
      BR_OP_BAD   = 2'd3
   } br_op_e;

   // A command is legal when it cannot overflow/underflow the stack and
   // an ELSE has not already been used at the current nesting level.
   function automatic logic br_cmd_legal(input br_op_e op,
                                         input logic   at_max,
                                         input logic   at_zero,
                                         input logic   else_top);
      case (op)
         BR_OP_IF:    return !at_max;
         BR_OP_ELSE:  return !at_zero && !else_top;
         BR_OP_ENDIF: return !at_zero;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pstack_ctrl_if.sv
// Command/response handshake plus PStack strobe bus between scheduler and controller.
// Latency: wires only.
// Backpressure: cmd_valid/cmd_ready and resp_valid/resp_ready handshakes.
import pstack_ctrl_pkg::*;

interface pstack_ctrl_if #(
   parameter int N_CORES = PSTACK_N_CORES,
   parameter int DEPTH   = PSTACK_DEPTH
);
   localparam int DW = $clog2(DEPTH + 1);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [N_CORES-1:0] cmd_cond;
   logic               resp_valid;
   logic               resp_ready;
   logic               resp_skip;
   logic               resp_uniform;
   logic               resp_err;
   logic [N_CORES-1:0] ps_d;
   logic               ps_push;
   logic               ps_pop;
   logic               ps_comp;
   logic               ps_all_true;
   logic               ps_all_false;
   logic [DW-1:0]      depth;

   // Controller side
   modport ctrl (
      input  cmd_valid, cmd_op, cmd_cond, resp_ready, ps_all_true, ps_all_false,
      output cmd_ready, resp_valid, resp_skip, resp_uniform, resp_err,
             ps_d, ps_push, ps_pop, ps_comp, depth
   );

   // Scheduler / PStack side
   modport sched (
      output cmd_valid, cmd_op, cmd_cond, resp_ready, ps_all_true, ps_all_false,
      input  cmd_ready, resp_valid, resp_skip, resp_uniform, resp_err,
             ps_d, ps_push, ps_pop, ps_comp, depth
   );

endinterface

// File: rtl/pstack_ctrl.sv
// Drives PStack push/comp/pop for IF/ELSE/ENDIF commands and reports skip/uniform.
// Latency: legal cmd accepted at T -> strobe T+1, response T+3; rejected cmd -> response T+1.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until resp_ready.
import pstack_ctrl_pkg::*;

module pstack_ctrl #(
   parameter int N_CORES = PSTACK_N_CORES,
   parameter int DEPTH   = PSTACK_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   pstack_ctrl_if.ctrl   bus
);

   localparam int DW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e             r_state;
   state_e             w_next;
   br_op_e             r_op;
   logic [N_CORES-1:0] r_cond;
   logic [DW-1:0]      r_depth;
   logic [DEPTH-1:0]   r_else_seen;
   logic               r_skip;
   logic               r_uniform;
   logic               r_err;

   logic               w_accept;
   logic               w_legal;
   logic               w_at_max;
   logic               w_at_zero;
   logic [DW-1:0]      w_top_idx;
   logic               w_else_top;
   logic               w_resp_hs;

   // At depth 0 the top index wraps high and the shift yields zero, which
   // is harmless because ELSE at depth 0 is rejected by the zero check.
   assign w_top_idx  = r_depth - DW'(1);
   assign w_at_max   = (r_depth == DW'(DEPTH));
   assign w_at_zero  = (r_depth == '0);
   assign w_else_top = |(r_else_seen & (DEPTH'(1) << w_top_idx));
   assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
   assign w_legal    = br_cmd_legal(br_op_e'(bus.cmd_op), w_at_max, w_at_zero, w_else_top);
   assign w_resp_hs  = (r_state == S_RESP) && bus.resp_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and handshake/strobe outputs
   always_comb begin
      w_next           = r_state;
      bus.cmd_ready    = 1'b0;
      bus.resp_valid   = 1'b0;
      bus.resp_skip    = 1'b0;
      bus.resp_uniform = 1'b0;
      bus.resp_err     = 1'b0;
      bus.ps_push      = 1'b0;
      bus.ps_pop       = 1'b0;
      bus.ps_comp      = 1'b0;
      bus.ps_d         = '0;
      bus.depth        = r_depth;
      case (r_state)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (w_accept) w_next = w_legal ? S_ISSUE : S_RESP;
         end
         S_ISSUE: begin
            bus.ps_d    = r_cond;
            bus.ps_push = (r_op == BR_OP_IF);
            bus.ps_comp = (r_op == BR_OP_ELSE);
            bus.ps_pop  = (r_op == BR_OP_ENDIF);
            w_next      = S_SETTLE;
         end
         S_SETTLE: begin
            bus.ps_d = r_cond;
            w_next   = S_RESP;
         end
         S_RESP: begin
            bus.ps_d         = r_err ? '0 : r_cond;
            bus.resp_valid   = 1'b1;
            bus.resp_skip    = r_skip;
            bus.resp_uniform = r_uniform;
            bus.resp_err     = r_err;
            if (w_resp_hs) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Latch the command and its legality verdict on acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op   <= BR_OP_IF;
         r_cond <= '0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_op   <= br_op_e'(bus.cmd_op);
         r_cond <= bus.cmd_cond;
         r_err  <= !w_legal;
      end
   end

   // Capture PStack flags once the update has settled; rejected commands report zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_skip    <= 1'b0;
         r_uniform <= 1'b0;
      end else if (w_accept) begin
         r_skip    <= 1'b0;
         r_uniform <= 1'b0;
      end else if (r_state == S_SETTLE) begin
         r_skip    <= bus.ps_all_false;
         r_uniform <= bus.ps_all_true;
      end
   end

   // Nesting depth and per-level ELSE bookkeeping, updated with the strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth     <= '0;
         r_else_seen <= '0;
      end else if (r_state == S_ISSUE) begin
         case (r_op)
            BR_OP_IF: begin
               r_depth     <= r_depth + DW'(1);
               r_else_seen <= r_else_seen & ~(DEPTH'(1) << r_depth);
            end
            BR_OP_ELSE: begin
               r_else_seen <= r_else_seen | (DEPTH'(1) << w_top_idx);
            end
            BR_OP_ENDIF: begin
               r_depth     <= r_depth - DW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pstack_ctrl.sv
// Bench for pstack_ctrl with a behavioural PStack attached and a nesting-level reference model.
// Latency: checks strobe at T+1 and response at T+3 (T+1 for rejected commands).
// Backpressure: holds resp_ready low for a number of cycles and checks the response stays put.
import pstack_ctrl_pkg::*;

module tb_pstack_ctrl;

   localparam int NC = 4;
   localparam int DP = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pstack_ctrl_if #(.N_CORES(NC), .DEPTH(DP)) bus ();

   pstack_ctrl #(.N_CORES(NC), .DEPTH(DP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural PStack: each entry is the active mask at that level
   logic [NC-1:0] ps_mem [DP];
   int            ps_sp;
   logic [NC-1:0] ps_act;
   always_comb ps_act = (ps_sp == 0) ? {NC{1'b1}} : ps_mem[ps_sp-1];
   assign bus.ps_all_true  = (ps_act == {NC{1'b1}});
   assign bus.ps_all_false = (ps_act == '0);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ps_sp <= 0;
      end else if (bus.ps_push && ps_sp < DP) begin
         ps_mem[ps_sp] <= ps_act & bus.ps_d;
         ps_sp         <= ps_sp + 1;
      end else if (bus.ps_comp && ps_sp > 0) begin
         ps_mem[ps_sp-1] <= ((ps_sp >= 2) ? ps_mem[ps_sp-2] : {NC{1'b1}}) & ~ps_mem[ps_sp-1];
      end else if (bus.ps_pop && ps_sp > 0) begin
         ps_sp <= ps_sp - 1;
      end
   end

   // Reference model: one entry per open IF, with its condition and whether ELSE was taken
   logic [NC-1:0] m_cond [$];
   bit            m_else [$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [NC-1:0] cond, input int hold);
      int d, cyc, npush, npop, ncomp, nmulti, scyc;
      bit e, xs, xu;
      logic [NC-1:0] act, sd;
      logic s_skip, s_uni, s_err;
      d = m_cond.size();
      case (op)
         2'd0:    e = (d == DP);
         2'd1:    e = (d == 0) || m_else[d-1];
         2'd2:    e = (d == 0);
         default: e = 1'b1;
      endcase
      if (!e) begin
         if (op == 2'd0) begin m_cond.push_back(cond); m_else.push_back(1'b0); end
         else if (op == 2'd1) m_else[d-1] = 1'b1;
         else begin void'(m_cond.pop_back()); void'(m_else.pop_back()); end
      end
      act = {NC{1'b1}};
      foreach (m_cond[i]) act &= m_else[i] ? ~m_cond[i] : m_cond[i];
      xs = !e && (act == '0);
      xu = !e && (act == {NC{1'b1}});

      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = op;
      bus.cmd_cond   = cond;
      bus.resp_ready = 1'b0;
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_cond  = NC'($urandom);
      cyc = 1; npush = 0; npop = 0; ncomp = 0; nmulti = 0; scyc = 0; sd = '0;
      while (bus.resp_valid !== 1'b1 && cyc < 12) begin
         chk("cmd_ready_busy", bus.cmd_ready, 0);
         if (bus.ps_push) begin npush++; scyc = cyc; sd = bus.ps_d; end
         if (bus.ps_pop)  begin npop++;  scyc = cyc; end
         if (bus.ps_comp) begin ncomp++; scyc = cyc; end
         if (32'(bus.ps_push) + 32'(bus.ps_pop) + 32'(bus.ps_comp) > 1) nmulti++;
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, e ? 1 : 3);
      chk("n_push", npush, (!e && op == 2'd0) ? 1 : 0);
      chk("n_comp", ncomp, (!e && op == 2'd1) ? 1 : 0);
      chk("n_pop",  npop,  (!e && op == 2'd2) ? 1 : 0);
      chk("multi_strobe", nmulti, 0);
      if (!e) chk("strobe_cycle", scyc, 1);
      if (!e && op == 2'd0) chk("ps_d_push", sd, cond);
      chk("strobes_resp", {bus.ps_push, bus.ps_pop, bus.ps_comp}, 0);
      chk("resp_err", bus.resp_err, e);
      chk("resp_skip", bus.resp_skip, xs);
      chk("resp_uniform", bus.resp_uniform, xu);
      chk("depth", bus.depth, m_cond.size());
      chk("ps_d_resp", bus.ps_d, e ? '0 : cond);
      s_skip = bus.resp_skip; s_uni = bus.resp_uniform; s_err = bus.resp_err;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", bus.resp_valid, 1);
         chk("hold_ready", bus.cmd_ready, 0);
         chk("hold_skip", bus.resp_skip, s_skip);
         chk("hold_uniform", bus.resp_uniform, s_uni);
         chk("hold_err", bus.resp_err, s_err);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("resp_valid_drop", bus.resp_valid, 0);
      chk("cmd_ready_back", bus.cmd_ready, 1);
      chk("ps_d_idle", bus.ps_d, 0);
   endtask

   initial begin
      int r;
      reset          = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'd0;
      bus.cmd_cond   = '0;
      bus.resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_resp", {bus.resp_valid, bus.resp_skip, bus.resp_uniform, bus.resp_err}, 0);
      chk("rst_strobes", {bus.ps_push, bus.ps_pop, bus.ps_comp}, 0);
      chk("rst_ps_d", bus.ps_d, 0);
      chk("rst_depth", bus.depth, 0);
      reset = 1'b0;

      // Basic IF, nested uniform/skip, ELSE use and reuse
      run_cmd(2'd0, 4'b1010, 0);
      run_cmd(2'd2, 4'b0000, 0);
      run_cmd(2'd0, 4'b1111, 0);
      run_cmd(2'd0, 4'b0000, 0);
      run_cmd(2'd2, 4'b0000, 0);
      run_cmd(2'd2, 4'b0000, 0);
      run_cmd(2'd0, 4'b1010, 0);
      run_cmd(2'd1, 4'b0000, 0);
      run_cmd(2'd1, 4'b0000, 0);
      run_cmd(2'd2, 4'b0000, 0);
      // Underflow and illegal op
      run_cmd(2'd2, 4'b0000, 0);
      run_cmd(2'd3, 4'b1111, 0);
      // Fill to capacity, overflow, then drain
      repeat (DP) run_cmd(2'd0, 4'b1111, 0);
      run_cmd(2'd0, 4'b1111, 0);
      repeat (DP) run_cmd(2'd2, 4'b0000, 0);
      // Response backpressure
      run_cmd(2'd0, 4'b0110, 5);
      run_cmd(2'd2, 4'b0000, 3);

      // Reset while the push strobe is on the wire
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd0;
      bus.cmd_cond  = 4'b1100;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("issue_push", bus.ps_push, 1);
      reset = 1'b1;
      #1;
      chk("midrst_strobes", {bus.ps_push, bus.ps_pop, bus.ps_comp}, 0);
      chk("midrst_depth", bus.depth, 0);
      chk("midrst_cmd_ready", bus.cmd_ready, 1);
      chk("midrst_resp_valid", bus.resp_valid, 0);
      chk("midrst_ps_d", bus.ps_d, 0);
      m_cond.delete();
      m_else.delete();
      @(negedge clk);
      reset = 1'b0;

      // Randomized command mix against the reference model
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         run_cmd((r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                 NC'($urandom), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pstack_ctrl.md
Name: pstack_ctrl

Overview:
- Command-side driver for the predicate stack (PStack) in the SM scheduler.
- Accepts IF / ELSE / ENDIF branch commands from the instruction decoder over a valid/ready handshake, each with a per-core condition mask.
- Sequences exactly one push, comp or pop strobe to PStack per command, then returns a response with the resulting skip and uniform flags.
- Tracks stack depth and per-level ELSE usage, and rejects overflow, underflow and illegal sequences without touching the stack.

Parameters:
- N_CORES, default `N_CORES: lane count, and the width of the condition mask and ps_d.
- DEPTH, default 8: maximum nesting depth; must match the PStack capacity.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command: 0 = IF, 1 = ELSE, 2 = ENDIF, 3 = illegal.
- cmd_cond  in  N_CORES  per-core branch condition; used by IF only.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_skip  out  1  new active mask is all zero; scheduler jumps to the branch target.
- resp_uniform  out  1  new active mask is all ones.
- resp_err  out  1  command rejected.
- ps_d  out  N_CORES  mask presented to PStack.
- ps_push  out  1  one-cycle push strobe to PStack.
- ps_pop  out  1  one-cycle pop strobe to PStack.
- ps_comp  out  1  one-cycle complement strobe to PStack.
- ps_all_true  in  1  PStack flag: active mask is all ones.
- ps_all_false  in  1  PStack flag: active mask is all zero.
- depth  out  $clog2(DEPTH+1)  current nesting level.

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE.
  - cmd_ready = 1; resp_valid, resp_skip, resp_uniform and resp_err = 0.
  - All ps_* strobes = 0; ps_d = 0.
  - depth = 0; all else_seen bits = 0.
  - Reset mid-sequence abandons the command; PStack is reset by the same signal.
- States: IDLE, ISSUE, SETTLE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch cmd_op and cmd_cond, then run the legality check.
  - Illegal commands (op 3; IF with depth == DEPTH; ELSE with depth == 0; ELSE with else_seen[depth-1] = 1; ENDIF with depth == 0) go to RESP with resp_err = 1. No strobe is issued and depth/else_seen are unchanged.
  - Legal commands go to ISSUE.
- ISSUE (exactly one cycle), per op:
  - IF: ps_push = 1 and ps_d = latched cond; depth increments; else_seen[new depth-1] cleared.
  - ELSE: ps_comp = 1; else_seen[depth-1] set.
  - ENDIF: ps_pop = 1; depth decrements.
  - Only one strobe is ever high in any cycle.
  - ps_d holds the latched cond from ISSUE through RESP and is 0 otherwise.
- SETTLE: one cycle with no strobes, so PStack output and flags reflect the update.
- RESP:
  - resp_valid = 1.
  - resp_skip = ps_all_false and resp_uniform = ps_all_true, both sampled on entry and held.
  - resp_err = 0 for legal commands.
  - For error responses, resp_skip = 0 and resp_uniform = 0.
  - Response fields hold stable until resp_valid && resp_ready, then go to IDLE; cmd_ready rises the next cycle.
- Latency:
  - Legal command accepted at edge T: strobe in cycle T+1, resp_valid from T+3.
  - Error: resp_valid from T+1.
  - Throughput: at most one command per 4 cycles.
- cmd_ready = 0 in every state except IDLE; commands arriving then are not accepted.
- depth saturates logically: the checks prevent it going above DEPTH or below 0.

Decomposition:
- constants.sv gains the op encodings `BR_OP_IF, `BR_OP_ELSE, `BR_OP_ENDIF and the default `PSTACK_DEPTH.
- The FSM state enum is local to the module.
- No sub-module: depth counter, else_seen vector and FSM fit in one module (about 180 lines).
- Integration: pstack_ctrl and PStack are instantiated side by side in the Scheduler.

Test Plan (N_CORES = 4, DEPTH = 8; PStack instance attached):
- IF with cond = 4'b1010 from reset -> ps_push pulse one cycle with ps_d = 1010; resp at T+3 with skip = 0, uniform = 0, err = 0; depth = 1.
- IF 1111, then IF 0000 -> first resp uniform = 1; second resp skip = 1; depth = 2.
- IF 1010, ELSE, ELSE -> ELSE gives ps_comp pulse, mask 0101, skip = 0; second ELSE gives err = 1, no strobe, depth stays 1.
- ENDIF at depth 0 and cmd_op = 3 -> err = 1 at T+1; ps_push, ps_pop and ps_comp never asserted.
- 8 IFs of 1111, then a 9th -> ninth err = 1, depth = 8; then 8 ENDIFs -> ps_pop pulses, depth 0, all err = 0.
- Hold resp_ready = 0 for 5 cycles -> resp fields stable and cmd_ready = 0; assert reset in ISSUE -> strobes drop immediately, depth = 0, cmd_ready = 1.
